// File: rtl/airi5c_wb_commit_if.sv
// Bundles the signals between the WB pipeline register, the data-memory
// read-response channel and the register file/CSR side of the commit stage.
//   slave  : used by airi5c_wb_commit (consumes WB payload and dmem response,
//            drives stall_WB, the rf write port, retire and load faults)
//   master : used by whatever drives the WB payload and response (e.g. a bench)
// XPR_LEN : datapath width.
interface airi5c_wb_commit_if #(
    parameter int XPR_LEN = 32
);
    // WB pipeline register payload
    logic               prev_killed_WB;
    logic               had_ex_WB;
    logic               valid_WB;
    logic               wr_reg_WB;
    logic [4:0]         reg_to_wr_WB;
    logic               is_load_WB;
    logic [1:0]         ld_size_WB;
    logic               ld_unsigned_WB;
    logic [1:0]         ld_offset_WB;
    logic [XPR_LEN-1:0] result_WB;
    logic               flush_WB;
    // data-memory read response
    logic               dmem_rvalid;
    logic [XPR_LEN-1:0] dmem_rdata;
    logic               dmem_rerr;
    // commit-stage outputs
    logic               stall_WB;
    logic               rf_wen;
    logic [4:0]         rf_waddr;
    logic [XPR_LEN-1:0] rf_wdata;
    logic               retire;
    logic               load_fault;
    logic               fault_timeout;

    modport slave (
        input  prev_killed_WB, had_ex_WB, valid_WB, wr_reg_WB, reg_to_wr_WB,
               is_load_WB, ld_size_WB, ld_unsigned_WB, ld_offset_WB, result_WB,
               flush_WB, dmem_rvalid, dmem_rdata, dmem_rerr,
        output stall_WB, rf_wen, rf_waddr, rf_wdata, retire, load_fault,
               fault_timeout
    );

    modport master (
        output prev_killed_WB, had_ex_WB, valid_WB, wr_reg_WB, reg_to_wr_WB,
               is_load_WB, ld_size_WB, ld_unsigned_WB, ld_offset_WB, result_WB,
               flush_WB, dmem_rvalid, dmem_rdata, dmem_rerr,
        input  stall_WB, rf_wen, rf_waddr, rf_wdata, retire, load_fault,
               fault_timeout
    );
endinterface

// File: rtl/airi5c_wb_commit.sv
// Writeback/commit stage.
// Completes loads from the dmem read-response channel (byte/half/word
// alignment plus sign/zero extension), drives the register-file write port,
// holds the WB pipeline register via stall_WB while a load response is
// outstanding, and reports retirement and load bus faults (error response or
// response timeout).
//
// Ports:
//   clk, nreset   clock, asynchronous active-low reset
//   bus           airi5c_wb_commit_if.slave (WB payload, dmem response,
//                 stall_WB, rf_wen/rf_waddr/rf_wdata, retire, load_fault,
//                 fault_timeout)
//   instret*      only with AIRI5C_WB_INSTRET_EN defined: 64-bit retired
//                 instruction counter with a 32-bit half-word write port
//
// Parameters:
//   XPR_LEN       datapath width
//   LOAD_TIMEOUT  WAIT cycles (1..255) without a response before a timeout fault
//
// Optional feature macro: AIRI5C_WB_INSTRET_EN
module airi5c_wb_commit #(
    parameter int XPR_LEN      = 32,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 nreset,
`ifdef AIRI5C_WB_INSTRET_EN
    input  logic                 instret_wen,
    input  logic [31:0]          instret_wdata,
    input  logic                 instret_hi,
    output logic [63:0]          instret,
`endif
    airi5c_wb_commit_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(LOAD_TIMEOUT);

    state_t             state_reg;
    logic [7:0]         cnt_reg;
    logic               rf_wen_reg;
    logic [4:0]         rf_waddr_reg;
    logic [XPR_LEN-1:0] rf_wdata_reg;
    logic               retire_reg;
    logic               load_fault_reg;
    logic               fault_timeout_reg;

    logic               live;
    logic               live_load;
    logic               wen_req;
    logic               timeout_hit;
    logic               stall;

    assign live      = bus.valid_WB & ~bus.prev_killed_WB & ~bus.had_ex_WB & ~bus.flush_WB;
    assign live_load = live & bus.is_load_WB;
    assign wen_req   = bus.wr_reg_WB & (bus.reg_to_wr_WB != 5'd0);
    // The counter holds the number of completed WAIT cycles; this cycle is
    // the last one allowed when it would reach the limit.
    assign timeout_hit = ((cnt_reg + 8'd1) == TIMEOUT_LIM);

    // ---------------- load data alignment ----------------
    logic [7:0]         byte_lane [4];
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [XPR_LEN-1:0] ld_data;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign byte_lane[gi] = bus.dmem_rdata[8*gi +: 8];
    end

    always_comb begin
        ld_byte = byte_lane[bus.ld_offset_WB];
        ld_half = bus.ld_offset_WB[1] ? {byte_lane[3], byte_lane[2]}
                                      : {byte_lane[1], byte_lane[0]};
        case (bus.ld_size_WB)
            2'b00:   ld_data = {{(XPR_LEN-8){ld_byte[7] & ~bus.ld_unsigned_WB}}, ld_byte};
            2'b01:   ld_data = {{(XPR_LEN-16){ld_half[15] & ~bus.ld_unsigned_WB}}, ld_half};
            default: ld_data = bus.dmem_rdata;    // 10 and 11 both mean word
        endcase
    end

    // ---------------- stall (combinational) ----------------
    // In WAIT the stall drops in the very cycle the load resolves (response,
    // flush or timeout) so the pipeline register advances past it exactly once.
    // In DRAIN a new load is held until the stale response has been absorbed.
    always_comb begin
        stall = 1'b0;
        case (state_reg)
            S_IDLE:  stall = live_load & ~bus.dmem_rvalid;
            S_WAIT:  stall = ~(bus.flush_WB | bus.dmem_rvalid | timeout_hit);
            S_DRAIN: stall = live_load;
            default: stall = 1'b0;
        endcase
    end

    // ---------------- FSM with registered outputs ----------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_reg         <= S_IDLE;
            cnt_reg           <= 8'd0;
            rf_wen_reg        <= 1'b0;
            rf_waddr_reg      <= 5'd0;
            rf_wdata_reg      <= '0;
            retire_reg        <= 1'b0;
            load_fault_reg    <= 1'b0;
            fault_timeout_reg <= 1'b0;
        end else begin
            // pulses default low; address/data hold their last commit
            rf_wen_reg        <= 1'b0;
            retire_reg        <= 1'b0;
            load_fault_reg    <= 1'b0;
            fault_timeout_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (live && !bus.is_load_WB) begin
                        retire_reg   <= 1'b1;
                        rf_wen_reg   <= wen_req;
                        rf_waddr_reg <= bus.reg_to_wr_WB;
                        rf_wdata_reg <= bus.result_WB;
                    end else if (live_load && bus.dmem_rvalid) begin
                        if (bus.dmem_rerr) begin
                            load_fault_reg <= 1'b1;
                        end else begin
                            retire_reg   <= 1'b1;
                            rf_wen_reg   <= wen_req;
                            rf_waddr_reg <= bus.reg_to_wr_WB;
                            rf_wdata_reg <= ld_data;
                        end
                    end else if (live_load) begin
                        state_reg <= S_WAIT;
                        cnt_reg   <= 8'd0;
                    end
                end
                S_WAIT: begin
                    cnt_reg <= cnt_reg + 8'd1;
                    if (bus.flush_WB) begin
                        // a response arriving with the flush is dropped here;
                        // otherwise it is still owed and must be drained
                        state_reg <= bus.dmem_rvalid ? S_IDLE : S_DRAIN;
                    end else if (bus.dmem_rvalid) begin
                        state_reg <= S_IDLE;
                        if (bus.dmem_rerr) begin
                            load_fault_reg <= 1'b1;
                        end else begin
                            retire_reg   <= 1'b1;
                            rf_wen_reg   <= wen_req;
                            rf_waddr_reg <= bus.reg_to_wr_WB;
                            rf_wdata_reg <= ld_data;
                        end
                    end else if (timeout_hit) begin
                        load_fault_reg    <= 1'b1;
                        fault_timeout_reg <= 1'b1;
                        state_reg         <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (live && !bus.is_load_WB) begin
                        retire_reg   <= 1'b1;
                        rf_wen_reg   <= wen_req;
                        rf_waddr_reg <= bus.reg_to_wr_WB;
                        rf_wdata_reg <= bus.result_WB;
                    end
                    // the first response here belongs to the abandoned load
                    if (bus.dmem_rvalid) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.stall_WB      = stall;
    assign bus.rf_wen        = rf_wen_reg;
    assign bus.rf_waddr      = rf_waddr_reg;
    assign bus.rf_wdata      = rf_wdata_reg;
    assign bus.retire        = retire_reg;
    assign bus.load_fault    = load_fault_reg;
    assign bus.fault_timeout = fault_timeout_reg;

`ifdef AIRI5C_WB_INSTRET_EN
    // retired-instruction counter; a software write overrides the increment
    logic [63:0] instret_reg;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            instret_reg <= 64'd0;
        end else if (instret_wen) begin
            if (instret_hi) begin
                instret_reg[63:32] <= instret_wdata;
            end else begin
                instret_reg[31:0]  <= instret_wdata;
            end
        end else if (retire_reg) begin
            instret_reg <= instret_reg + 64'd1;
        end
    end

    assign instret = instret_reg;
`endif

endmodule

// File: tb/tb_airi5c_wb_commit.sv
`timescale 1ns/1ps
module tb_airi5c_wb_commit;
    localparam int TO = 4;

    logic clk    = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    airi5c_wb_commit_if #(.XPR_LEN(32)) bus ();

`ifdef AIRI5C_WB_INSTRET_EN
    logic        instret_wen   = 1'b0;
    logic [31:0] instret_wdata = 32'd0;
    logic        instret_hi    = 1'b0;
    logic [63:0] instret;
`endif

    airi5c_wb_commit #(.XPR_LEN(32), .LOAD_TIMEOUT(TO)) dut (
        .clk           (clk),
        .nreset        (nreset),
`ifdef AIRI5C_WB_INSTRET_EN
        .instret_wen   (instret_wen),
        .instret_wdata (instret_wdata),
        .instret_hi    (instret_hi),
        .instret       (instret),
`endif
        .bus           (bus.slave)
    );

    typedef struct packed {
        logic        retire;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        fault;
        logic        tmo;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   errors  = 0;
    bit   stale_pending = 1'b0;   // an abandoned load still owes a response
    bit   force_stale   = 1'b0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] load_val(input logic [31:0] rdata, input logic [1:0] size,
                                             input logic [1:0] off, input logic uns);
        logic [31:0] v;
        if (size == 2'd0) begin
            v = (rdata >> (8 * off)) & 32'h0000_00FF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            v = (rdata >> (16 * (off / 2))) & 32'h0000_FFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    function automatic exp_t commit_exp(input logic [4:0] rd, input logic wr, input logic [31:0] d);
        exp_t e;
        e = '0;
        e.retire = 1'b1;
        e.wen    = wr && (rd != 5'd0);
        e.waddr  = rd;
        e.wdata  = d;
        return e;
    endfunction

    function automatic exp_t fault_exp(input logic tmo);
        exp_t e;
        e = '0;
        e.fault = 1'b1;
        e.tmo   = tmo;
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : mon
        exp_t e;
        if (nreset && (bus.retire || bus.load_fault || bus.rf_wen || bus.fault_timeout)) begin
            vectors++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got retire=%0b wen=%0b fault=%0b tmo=%0b, required none",
                         bus.retire, bus.rf_wen, bus.load_fault, bus.fault_timeout);
            end else begin
                e = q.pop_front();
                if (bus.retire !== e.retire || bus.rf_wen !== e.wen || bus.load_fault !== e.fault ||
                    bus.fault_timeout !== e.tmo ||
                    (e.wen && (bus.rf_waddr !== e.waddr || bus.rf_wdata !== e.wdata))) begin
                    errors++;
                    $display("FAIL commit got ret=%0b wen=%0b a=%0d d=%h flt=%0b tmo=%0b, required ret=%0b wen=%0b a=%0d d=%h flt=%0b tmo=%0b",
                             bus.retire, bus.rf_wen, bus.rf_waddr, bus.rf_wdata, bus.load_fault, bus.fault_timeout,
                             e.retire, e.wen, e.waddr, e.wdata, e.fault, e.tmo);
                end else begin
                    $display("commit ok ret=%0b wen=%0b a=%0d d=%h flt=%0b tmo=%0b",
                             e.retire, e.wen, e.waddr, e.wdata, e.fault, e.tmo);
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic no_rsp();
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'd0;
        bus.dmem_rerr   = 1'b0;
    endtask

    task automatic rsp(input logic [31:0] d, input logic err);
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = d;
        bus.dmem_rerr   = err;
    endtask

    // inputs are applied at a falling edge; stall is checked just after, then
    // the rising edge consumes them
    task automatic step(input logic exp_stall, input string tag);
        #1;
        vectors++;
        if (bus.stall_WB !== exp_stall) begin
            errors++;
            $display("FAIL stall_%s got %0b required %0b", tag, bus.stall_WB, exp_stall);
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        vectors++;
        if ({bus.retire, bus.rf_wen, bus.load_fault, bus.fault_timeout, bus.rf_waddr, bus.rf_wdata} !== '0
            || bus.stall_WB !== 1'b0) begin
            errors++;
            $display("FAIL reset_%s got ret=%0b wen=%0b flt=%0b tmo=%0b a=%0d d=%h stall=%0b required all 0",
                     tag, bus.retire, bus.rf_wen, bus.load_fault, bus.fault_timeout,
                     bus.rf_waddr, bus.rf_wdata, bus.stall_WB);
        end
    endtask

    // kind: 0 bubble, 1 killed, 2 exception, 3 ALU, 4 load
    // lat: WAIT cycle on which the response arrives (0 = same cycle)
    // flush_at: WAIT cycle on which flush_WB is raised (-1 = never)
    task automatic issue(input int kind, input logic [4:0] rd, input logic wr, input logic [31:0] res,
                         input logic [1:0] size, input logic uns, input logic [1:0] off,
                         input logic [31:0] rdata, input int lat, input logic rerr, input int flush_at);
        exp_t e;
        bus.valid_WB       = (kind != 0);
        bus.prev_killed_WB = (kind == 1);
        bus.had_ex_WB      = (kind == 2);
        bus.flush_WB       = 1'b0;
        bus.wr_reg_WB      = wr;
        bus.reg_to_wr_WB   = rd;
        bus.result_WB      = res;
        bus.is_load_WB     = (kind == 4) || (kind < 3 && $urandom_range(0, 1) == 1);
        bus.ld_size_WB     = size;
        bus.ld_unsigned_WB = uns;
        bus.ld_offset_WB   = off;
        no_rsp();
        $display("issue kind=%0d rd=%0d wr=%0b res=%h sz=%0d u=%0b off=%0d rdata=%h lat=%0d err=%0b flush_at=%0d",
                 kind, rd, wr, res, size, uns, off, rdata, lat, rerr, flush_at);
        if (kind != 4) begin
            if (kind == 3) q.push_back(commit_exp(rd, wr, res));
            if (stale_pending && (force_stale || $urandom_range(0, 3) == 0)) begin
                rsp(32'hDEAD_BEEF, 1'b0);
                stale_pending = 1'b0;
            end else if (!stale_pending && $urandom_range(0, 7) == 0) begin
                rsp($urandom, 1'($urandom_range(0, 1)));   // stray response in IDLE
            end
            step(1'b0, "nonload");
            no_rsp();
            return;
        end
        if (stale_pending) begin
            int d;
            d = $urandom_range(0, 2);
            repeat (d) step(1'b1, "drain_hold");
            rsp(32'hDEAD_BEEF, 1'($urandom_range(0, 1)));
            step(1'b1, "drain_rsp");
            no_rsp();
            stale_pending = 1'b0;
        end
        e = rerr ? fault_exp(1'b0) : commit_exp(rd, wr, load_val(rdata, size, off, uns));
        if (lat == 0) begin
            rsp(rdata, rerr);
            q.push_back(e);
            step(1'b0, "ld_hit");
            no_rsp();
            return;
        end
        step(1'b1, "ld_issue");
        for (int w = 1; w <= TO; w++) begin
            if (w == flush_at) begin
                bus.flush_WB = 1'b1;
                if (lat == w) rsp(rdata, rerr);
                else          stale_pending = 1'b1;
                step(1'b0, "flush");
                no_rsp();
                bus.flush_WB = 1'b0;
                return;
            end
            if (w == lat) begin
                rsp(rdata, rerr);
                q.push_back(e);
                step(1'b0, "ld_rsp");
                no_rsp();
                return;
            end
            if (w == TO) begin
                q.push_back(fault_exp(1'b1));
                stale_pending = 1'b1;
                step(1'b0, "timeout");
                return;
            end
            step(1'b1, "ld_wait");
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.valid_WB = 1'b0; bus.prev_killed_WB = 1'b0; bus.had_ex_WB = 1'b0;
        bus.flush_WB = 1'b0; bus.wr_reg_WB = 1'b0; bus.reg_to_wr_WB = 5'd0;
        bus.is_load_WB = 1'b0; bus.ld_size_WB = 2'd0; bus.ld_unsigned_WB = 1'b0;
        bus.ld_offset_WB = 2'd0; bus.result_WB = 32'd0;
        no_rsp();
        repeat (3) @(negedge clk);
        check_reset_outputs("initial");
        nreset = 1'b1;
        @(negedge clk);
        check_reset_outputs("released");

        // directed scenarios
        issue(3, 5'd5,  1'b1, 32'h1234_5678, 2'd0, 1'b0, 2'd0, 32'd0,         0, 1'b0, -1);
        issue(4, 5'd9,  1'b1, 32'd0,         2'd0, 1'b0, 2'd3, 32'h80FF_0000, 3, 1'b0, -1);
        issue(4, 5'd10, 1'b1, 32'd0,         2'd0, 1'b1, 2'd3, 32'h80FF_0000, 3, 1'b0, -1);
        issue(4, 5'd11, 1'b1, 32'd0,         2'd1, 1'b0, 2'd2, 32'h8001_7FFF, 0, 1'b0, -1);
        issue(4, 5'd0,  1'b1, 32'd0,         2'd1, 1'b0, 2'd2, 32'h8001_7FFF, 0, 1'b0, -1);
        issue(4, 5'd3,  1'b1, 32'd0,         2'd2, 1'b0, 2'd0, 32'hCAFE_F00D, 2, 1'b1, -1);
        issue(4, 5'd4,  1'b1, 32'd0,         2'd2, 1'b0, 2'd0, 32'h1111_1111, 100, 1'b0, -1);
        force_stale = 1'b1;
        issue(0, 5'd0,  1'b0, 32'd0,         2'd0, 1'b0, 2'd0, 32'd0,         0, 1'b0, -1);
        force_stale = 1'b0;
        issue(4, 5'd6,  1'b1, 32'd0,         2'd2, 1'b0, 2'd0, 32'h2222_2222, 2, 1'b0, 1);
        force_stale = 1'b1;
        issue(3, 5'd7,  1'b1, 32'h0000_A5A5, 2'd0, 1'b0, 2'd0, 32'd0,         0, 1'b0, -1);
        force_stale = 1'b0;
        issue(1, 5'd8,  1'b1, 32'h5555_5555, 2'd0, 1'b0, 2'd0, 32'd0,         0, 1'b0, -1);
        issue(2, 5'd8,  1'b1, 32'h6666_6666, 2'd0, 1'b0, 2'd0, 32'd0,         0, 1'b0, -1);

        // reset in the middle of a WAIT
        bus.valid_WB = 1'b1; bus.prev_killed_WB = 1'b0; bus.had_ex_WB = 1'b0;
        bus.is_load_WB = 1'b1; bus.wr_reg_WB = 1'b1; bus.reg_to_wr_WB = 5'd12;
        no_rsp();
        $display("issue reset_mid_wait load rd=12");
        step(1'b1, "rst_ld");
        step(1'b1, "rst_wait");
        bus.valid_WB = 1'b0;
        nreset = 1'b0;
        #1;
        check_reset_outputs("mid_wait");
        @(negedge clk);
        nreset = 1'b1;
        stale_pending = 1'b0;
        rsp(32'hDEAD_BEEF, 1'b0);    // stray response after reset must be ignored
        step(1'b0, "stray_after_reset");
        no_rsp();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            int kind;
            r = $urandom_range(0, 9);
            kind = (r < 3) ? r : ((r < 6) ? 3 : 4);
            issue(kind, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 3) != 0), $urandom,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  $urandom, $urandom_range(0, TO + 2), 1'($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(1, TO) : -1);
        end

        // quiesce and make sure every expected response was seen
        bus.valid_WB = 1'b0;
        no_rsp();
        repeat (3) step(1'b0, "quiesce");
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty got %0d pending, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no completion, required finish");
        $fatal(1, "watchdog");
    end

endmodule
